// File: rtl/fme_pkg.sv
// Shared types and constants for the three-bank lane writer: FSM states,
// bank indices and lane-width derivation.
package fme_pkg;

  localparam int unsigned DATA_WIDTH_DEF = 8;
  localparam int unsigned LANES_DEF      = 16;
  localparam int unsigned NUM_BANKS      = 3;

  typedef enum logic {
    ST_FILL = 1'b0,
    ST_FULL = 1'b1
  } state_e;

  typedef logic [1:0] bank_idx_t;

  localparam bank_idx_t BANK0 = 2'd0;
  localparam bank_idx_t BANK1 = 2'd1;
  localparam bank_idx_t BANK2 = 2'd2;

  // Lanes carry two guard bits above the base sample width.
  function automatic int unsigned lane_width(input int unsigned dw);
    return dw + 2;
  endfunction

  // c1=0 selects bank0 regardless of c0.
  function automatic bank_idx_t bank_decode(input logic c1, input logic c0);
    if (!c1) return BANK0;
    return c0 ? BANK2 : BANK1;
  endfunction

  function automatic logic [NUM_BANKS-1:0] bank_onehot(input bank_idx_t idx);
    logic [NUM_BANKS-1:0] oh;
    oh = '0;
    case (idx)
      BANK0:   oh = 3'b001;
      BANK1:   oh = 3'b010;
      BANK2:   oh = 3'b100;
      default: oh = '0;
    endcase
    return oh;
  endfunction

endpackage

// File: rtl/fme_bank_reg.sv
// One bank of lane storage: a wide register with write enable and
// synchronous active-low reset.
module fme_bank_reg #(
  parameter int unsigned WIDTH = 160
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             we,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] data_q;
  logic [WIDTH-1:0] data_d;

  always_comb begin
    data_d = data_q;
    if (we) data_d = d;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) data_q <= '0;
    else        data_q <= data_d;
  end

  assign q = data_q;

endmodule

// File: rtl/demux3x16_bank_writer.sv
// Demultiplexes lane writes into three banks selected by {c1,c0}; presents
// the complete three-bank set downstream once every bank has been written.
module demux3x16_bank_writer
  import fme_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int unsigned LANES      = LANES_DEF
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic                                  c0,
  input  logic                                  c1,
  input  logic                                  in_valid,
  output logic                                  in_ready,
  input  logic [LANES*lane_width(DATA_WIDTH)-1:0]           in_data,
  output logic                                  out_valid,
  input  logic                                  out_ready,
  output logic [NUM_BANKS*LANES*lane_width(DATA_WIDTH)-1:0] out_data,
  output logic                                  overwrite
);

  localparam int unsigned LW     = lane_width(DATA_WIDTH);
  localparam int unsigned BANK_W = LANES * LW;

  state_e               state_q, state_d;
  logic [NUM_BANKS-1:0] filled_q, filled_d;
  logic                 out_valid_q, out_valid_d;
  logic                 overwrite_q, overwrite_d;
  logic [NUM_BANKS-1:0] wr_en;
  logic                 accept;
  bank_idx_t            sel;

  // Next-state, fill tracking and write enables.
  always_comb begin
    state_d     = state_q;
    filled_d    = filled_q;
    overwrite_d = 1'b0;
    wr_en       = '0;
    sel         = bank_decode(c1, c0);
    accept      = in_valid && (state_q == ST_FILL);
    case (state_q)
      ST_FILL: begin
        if (accept) begin
          wr_en       = bank_onehot(sel);
          overwrite_d = |(filled_q & wr_en);
          filled_d    = filled_q | wr_en;
          if (&filled_d) state_d = ST_FULL;
        end
      end
      ST_FULL: begin
        // Contents stay in the banks; only the fill flags are cleared.
        if (out_ready) begin
          state_d  = ST_FILL;
          filled_d = '0;
        end
      end
      default: state_d = ST_FILL;
    endcase
    out_valid_d = (state_d == ST_FULL);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_FILL;
      filled_q    <= '0;
      out_valid_q <= 1'b0;
      overwrite_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      filled_q    <= filled_d;
      out_valid_q <= out_valid_d;
      overwrite_q <= overwrite_d;
    end
  end

  for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
    fme_bank_reg #(
      .WIDTH (BANK_W)
    ) u_bank (
      .clk   (clk),
      .rst_n (rst_n),
      .we    (wr_en[b]),
      .d     (in_data),
      .q     (out_data[b*BANK_W +: BANK_W])
    );
  end

  assign in_ready  = (state_q == ST_FILL);
  assign out_valid = out_valid_q;
  assign overwrite = overwrite_q;

endmodule

// File: tb/tb_demux3x16_bank_writer.sv
// Directed table-driven bench for demux3x16_bank_writer with a short
// hand-written latency sequence at the end.
module tb_demux3x16_bank_writer;

  localparam int unsigned DW    = 8;
  localparam int unsigned LANES = 16;
  localparam int unsigned LW    = DW + 2;
  localparam int unsigned NV    = 28;

  logic                      clk;
  logic                      rst_n;
  logic                      c0, c1;
  logic                      in_valid;
  logic                      in_ready;
  logic [LANES*LW-1:0]       in_data;
  logic                      out_valid;
  logic                      out_ready;
  logic [3*LANES*LW-1:0]     out_data;
  logic                      overwrite;

  int errors = 0;
  int checks = 0;

  demux3x16_bank_writer #(
    .DATA_WIDTH (DW),
    .LANES      (LANES)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .c0        (c0),
    .c1        (c1),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .overwrite (overwrite)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic          rst_n;
    logic          c1;
    logic          c0;
    logic          iv;
    logic          ordy;
    logic [LW-1:0] base;
    logic          e_ir;
    logic          e_ov;
    logic          e_ow;
    int            idx;
    logic [LW-1:0] e_val;
    logic          e_zero;
  } vec_t;

  vec_t vecs [NV];
  int   nv = 0;

  task automatic add(input logic r, input logic v1, input logic v0, input logic iv,
                     input logic ordy, input logic [LW-1:0] base, input logic eir,
                     input logic eov, input logic eow, input int idx,
                     input logic [LW-1:0] ev, input logic ez);
    vecs[nv] = '{r, v1, v0, iv, ordy, base, eir, eov, eow, idx, ev, ez};
    nv++;
  endtask

  task automatic drive(input logic r, input logic v1, input logic v0, input logic iv,
                       input logic ordy, input logic [LW-1:0] base);
    rst_n     = r;
    c1        = v1;
    c0        = v0;
    in_valid  = iv;
    out_ready = ordy;
    for (int k = 0; k < int'(LANES); k++)
      in_data[k*LW +: LW] = LW'(base + LW'(k));
  endtask

  task automatic chk(input string name, input int row, input logic [LW-1:0] act,
                     input logic [LW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s row=%0d got=0x%0h expected=0x%0h", name, row, act, exp);
    end
  endtask

  initial begin
    logic [3*LANES*LW-1:0] zero_bus;
    int cyc;
    zero_bus = '0;
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0);

    // rst  c1 c0 iv or  base    ir ov ow idx val    zero
    add(0, 0, 0, 0, 0, 10'h000, 1, 0, 0,  0, 10'h000, 1);  // reset
    add(1, 0, 0, 0, 0, 10'h000, 1, 0, 0,  0, 10'h000, 1);
    add(1, 0, 0, 1, 1, 10'h001, 1, 0, 0,  0, 10'h001, 0);  // bank0
    add(1, 1, 0, 1, 1, 10'h101, 1, 0, 0, 16, 10'h101, 0);  // bank1
    add(1, 1, 1, 1, 1, 10'h201, 0, 1, 0, 32, 10'h201, 0);  // bank2 completes
    add(1, 0, 0, 0, 1, 10'h000, 1, 0, 0, 16, 10'h101, 0);  // handshake, retained
    add(1, 0, 1, 1, 0, 10'h3FF, 1, 0, 0,  0, 10'h3FF, 0);  // c1c0=01 -> bank0
    add(1, 1, 0, 1, 0, 10'h050, 1, 0, 0, 17, 10'h051, 0);
    add(1, 1, 1, 1, 0, 10'h060, 0, 1, 0,  0, 10'h3FF, 0);
    add(1, 0, 0, 0, 1, 10'h000, 1, 0, 0,  1, 10'h000, 0);  // lane1 wrapped
    add(1, 1, 0, 1, 0, 10'h111, 1, 0, 0, 16, 10'h111, 0);
    add(1, 1, 0, 1, 0, 10'h122, 1, 0, 1, 16, 10'h122, 0);  // overwrite bank1
    add(1, 0, 0, 1, 0, 10'h133, 1, 0, 0,  0, 10'h133, 0);
    add(1, 1, 1, 1, 0, 10'h144, 0, 1, 0, 31, 10'h131, 0);
    for (int i = 0; i < 5; i++)                             // stall in FULL
      add(1, 0, 0, 1, 0, 10'h2AA, 0, 1, 0, 0, 10'h133, 0);
    add(1, 0, 0, 1, 1, 10'h2AA, 1, 0, 0,  0, 10'h133, 0);  // no bypass
    add(1, 0, 0, 1, 0, 10'h2AA, 1, 0, 0,  0, 10'h2AA, 0);
    add(1, 1, 0, 1, 0, 10'h0F0, 1, 0, 0, 16, 10'h0F0, 0);
    add(0, 0, 0, 0, 0, 10'h000, 1, 0, 0, 16, 10'h000, 1);  // mid-set reset
    add(1, 1, 1, 1, 0, 10'h0AB, 1, 0, 0, 32, 10'h0AB, 0);
    add(1, 0, 0, 1, 0, 10'h0CD, 1, 0, 0,  0, 10'h0CD, 0);
    add(1, 0, 0, 1, 0, 10'h0CE, 1, 0, 1,  0, 10'h0CE, 0);
    add(1, 1, 0, 1, 1, 10'h0EF, 0, 1, 0, 16, 10'h0EF, 0);
    add(1, 0, 0, 0, 1, 10'h000, 1, 0, 0, 32, 10'h0AB, 0);

    for (int i = 0; i < nv; i++) begin
      drive(vecs[i].rst_n, vecs[i].c1, vecs[i].c0, vecs[i].iv, vecs[i].ordy, vecs[i].base);
      @(posedge clk);
      #1;
      chk("in_ready",  i, LW'(in_ready),  LW'(vecs[i].e_ir));
      chk("out_valid", i, LW'(out_valid), LW'(vecs[i].e_ov));
      chk("overwrite", i, LW'(overwrite), LW'(vecs[i].e_ow));
      chk("lane",      i, out_data[vecs[i].idx*LW +: LW], vecs[i].e_val);
      if (vecs[i].e_zero) begin
        checks++;
        if (out_data !== zero_bus) begin
          errors++;
          $display("FAIL out_data_zero row=%0d got nonzero expected all zero", i);
        end
      end
    end

    // Completing write in a fresh set: out_valid seen right after that edge.
    drive(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 10'h300);
    @(posedge clk); #1;
    drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 10'h310);
    @(posedge clk); #1;
    drive(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 10'h320);
    @(posedge clk); #1;
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 10'h000);
    cyc = 0;
    while (!out_valid && cyc < 4) begin
      @(posedge clk); #1;
      cyc++;
    end
    chk("latency", 100, LW'(cyc), LW'(0));
    chk("set_lane32", 100, out_data[32*LW +: LW], 10'h300);
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("drain_valid", 101, LW'(out_valid), LW'(0));
    chk("drain_ready", 101, LW'(in_ready), LW'(1));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
